// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: ROM port, redirect input, instruction handshake and status.
// Latency: none (wires only); the fetch stage registers the instruction path.
// Backpressure: instr_ready from decode holds instr/instr_pc/instr_valid stable while low.
interface instr_fetch_if #(
    parameter int AW = 5
);
    // ROM side
    logic [AW-1:0] rom_addr;
    logic          rom_oe;
    logic [31:0]   rom_data;

    // Control-flow redirect from execute
    logic          redirect_valid;
    logic [31:0]   redirect_pc;

    // Instruction handshake toward decode
    logic          instr_ready;
    logic          instr_valid;
    logic [31:0]   instr;
    logic [31:0]   instr_pc;

    // Status
    logic          halted;
    logic          fault;

    // Fetch stage side
    modport master (
        output rom_addr,
        output rom_oe,
        input  rom_data,
        input  redirect_valid,
        input  redirect_pc,
        input  instr_ready,
        output instr_valid,
        output instr,
        output instr_pc,
        output halted,
        output fault
    );

    // ROM / decode / execute side
    modport slave (
        input  rom_addr,
        input  rom_oe,
        output rom_data,
        output redirect_valid,
        output redirect_pc,
        output instr_ready,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        input  halted,
        input  fault
    );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: holds PC, reads the combinational ROM, registers one instruction for decode.
// Latency: one cycle from the fetch cycle (rom_oe high) to instr_valid.
// Backpressure: a held slot (instr_valid && !instr_ready) blocks fetching; redirect flushes it.
module instr_fetch #(
    parameter int          L        = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clock,
    input  logic              reset,
    instr_fetch_if.master     bus
);
    localparam int          AW       = $clog2(L);
    localparam logic [31:0] PC_LIMIT = 32'(4 * L);
    localparam logic [31:0] WFI      = 32'h10500073;
    localparam logic [31:0] NOP      = 32'h00000013;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        HALT_WFI   = 2'd1,
        HALT_FAULT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;

    logic        slot_free;
    logic        in_range;
    logic        xfer;
    logic        fetch;

    // Low redirect bits are dropped: targets are always word aligned.
    logic        unused_redirect_lsbs;
    assign unused_redirect_lsbs = &{1'b0, bus.redirect_pc[1:0]};

    // Slot/fetch qualification shared by next-state logic and the ROM enable.
    always_comb begin
        slot_free = !instr_valid_q || bus.instr_ready;
        in_range  = (pc_q < PC_LIMIT);
        xfer      = instr_valid_q && bus.instr_ready;
        fetch     = (state_q == RUN) && slot_free && !bus.redirect_valid && in_range;
    end

    // Next-state: redirect wins over everything; otherwise drain, then fetch or fault.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;

        if (bus.redirect_valid) begin
            // Flush the held instruction even if decode is stalled.
            pc_d          = {bus.redirect_pc[31:2], 2'b00};
            instr_valid_d = 1'b0;
            state_d       = RUN;
        end else begin
            if (xfer) begin
                instr_valid_d = 1'b0;
            end
            if ((state_q == RUN) && slot_free) begin
                if (in_range) begin
                    instr_d       = bus.rom_data;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    if (bus.rom_data == WFI) begin
                        // WFI is still handed to decode; the PC parks on it.
                        state_d = HALT_WFI;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end else begin
                    state_d       = HALT_FAULT;
                    instr_valid_d = 1'b0;
                end
            end
        end
    end

    // State, PC and instruction register with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            instr_q       <= NOP;
            instr_pc_q    <= 32'h0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // Outputs; the ROM enable is gated by reset so the ROM stays off while reset is held.
    assign bus.rom_addr    = pc_q[AW+1:2];
    assign bus.rom_oe      = fetch && !reset;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.halted      = (state_q != RUN);
    assign bus.fault       = (state_q == HALT_FAULT);
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: table-driven cycle vectors plus hand sequences for WFI and async reset.
// Latency: expectations are per cycle, sampled on the falling edge before each rising edge.
// Backpressure: instr_ready is driven from the vectors to exercise stalls and drains.
module tb_instr_fetch;
    localparam logic [31:0] WFI = 32'h10500073;
    localparam logic [31:0] NOP = 32'h00000013;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    logic [31:0] rom_mem [0:31];

    instr_fetch_if #(.AW(5)) bus();

    instr_fetch #(.L(32), .RESET_PC(32'h0)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    // Combinational ROM model
    assign bus.rom_data = rom_mem[bus.rom_addr];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        e_vld;
        logic [31:0] e_ipc;
        logic [31:0] e_instr;
        logic        e_halt;
        logic        e_flt;
        logic        e_oe;
        logic [4:0]  e_addr;
    } vec_t;

    vec_t vecs [0:21];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_status(input string tag, input logic vld, input logic halt,
                              input logic flt, input logic oe, input logic [4:0] addr);
        chk({tag, ".instr_valid"}, {31'd0, bus.instr_valid}, {31'd0, vld});
        chk({tag, ".halted"},      {31'd0, bus.halted},      {31'd0, halt});
        chk({tag, ".fault"},       {31'd0, bus.fault},       {31'd0, flt});
        chk({tag, ".rom_oe"},      {31'd0, bus.rom_oe},      {31'd0, oe});
        chk({tag, ".rom_addr"},    {27'd0, bus.rom_addr},    {27'd0, addr});
    endtask

    task automatic chk_instr(input string tag, input logic [31:0] ipc, input logic [31:0] ins);
        chk({tag, ".instr_pc"}, bus.instr_pc, ipc);
        chk({tag, ".instr"},    bus.instr,    ins);
    endtask

    task automatic vset(input int i, input logic rdy, input logic rv, input logic [31:0] rpc,
                        input logic vld, input logic [31:0] ipc, input logic [31:0] ins,
                        input logic halt, input logic flt, input logic oe, input logic [4:0] addr);
        vecs[i] = '{rdy, rv, rpc, vld, ipc, ins, halt, flt, oe, addr};
    endtask

    task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc);
        bus.instr_ready    = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        rom_mem[0] = 32'h002081b3;   // add
        rom_mem[1] = 32'h00108093;   // addi
        rom_mem[2] = 32'h0000a103;   // lw
        rom_mem[3] = 32'h00300013;
        rom_mem[4] = 32'h00400013;
        rom_mem[5] = 32'h00500013;
        rom_mem[6] = 32'h00600013;
        rom_mem[7] = 32'h00700013;
        for (int w = 8; w < 32; w++) rom_mem[w] = WFI;

        //      i  rdy rv  rpc    vld ipc     instr         halt flt oe addr
        vset( 0, 1, 0, 32'h0,  0, 32'h0,  NOP,          0, 0, 1, 5'd0);
        vset( 1, 1, 0, 32'h0,  1, 32'h0,  32'h002081b3, 0, 0, 1, 5'd1);
        vset( 2, 1, 0, 32'h0,  1, 32'h4,  32'h00108093, 0, 0, 1, 5'd2);
        vset( 3, 0, 0, 32'h0,  1, 32'h8,  32'h0000a103, 0, 0, 0, 5'd3);
        vset( 4, 0, 0, 32'h0,  1, 32'h8,  32'h0000a103, 0, 0, 0, 5'd3);
        vset( 5, 0, 0, 32'h0,  1, 32'h8,  32'h0000a103, 0, 0, 0, 5'd3);
        vset( 6, 1, 0, 32'h0,  1, 32'h8,  32'h0000a103, 0, 0, 1, 5'd3);
        vset( 7, 1, 0, 32'h0,  1, 32'hc,  32'h00300013, 0, 0, 1, 5'd4);
        vset( 8, 1, 0, 32'h0,  1, 32'h10, 32'h00400013, 0, 0, 1, 5'd5);
        vset( 9, 1, 0, 32'h0,  1, 32'h14, 32'h00500013, 0, 0, 1, 5'd6);
        vset(10, 1, 0, 32'h0,  1, 32'h18, 32'h00600013, 0, 0, 1, 5'd7);
        vset(11, 1, 0, 32'h0,  1, 32'h1c, 32'h00700013, 0, 0, 1, 5'd8);
        vset(12, 1, 0, 32'h0,  1, 32'h20, WFI,          1, 0, 0, 5'd8);
        vset(13, 0, 0, 32'h0,  0, 32'h20, WFI,          1, 0, 0, 5'd8);
        vset(14, 0, 1, 32'h13, 0, 32'h20, WFI,          1, 0, 0, 5'd8);
        vset(15, 0, 0, 32'h0,  0, 32'h20, WFI,          0, 0, 1, 5'd4);
        vset(16, 0, 1, 32'h80, 1, 32'h10, 32'h00400013, 0, 0, 0, 5'd5);
        vset(17, 0, 0, 32'h0,  0, 32'h10, 32'h00400013, 0, 0, 0, 5'd0);
        vset(18, 0, 0, 32'h0,  0, 32'h10, 32'h00400013, 1, 1, 0, 5'd0);
        vset(19, 0, 1, 32'h0,  0, 32'h10, 32'h00400013, 1, 1, 0, 5'd0);
        vset(20, 1, 0, 32'h0,  0, 32'h10, 32'h00400013, 0, 0, 1, 5'd0);
        vset(21, 1, 0, 32'h0,  1, 32'h0,  32'h002081b3, 0, 0, 1, 5'd1);

        // Reset state, checked while reset is still held
        reset = 1'b1;
        drive(1'b1, 1'b0, 32'h0);
        @(negedge clock);
        chk_status("rst", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk_instr("rst", 32'h0, NOP);
        @(posedge clock);
        #1 reset = 1'b0;

        // Table: inputs applied after the rising edge, outputs compared on the falling edge
        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
            @(negedge clock);
            chk_status($sformatf("v%0d", i), vecs[i].e_vld, vecs[i].e_halt,
                       vecs[i].e_flt, vecs[i].e_oe, vecs[i].e_addr);
            if (vecs[i].e_vld)
                chk_instr($sformatf("v%0d", i), vecs[i].e_ipc, vecs[i].e_instr);
            @(posedge clock);
            #1;
        end

        // Halted on WFI with the WFI still held, then redirect to an unaligned target
        drive(1'b0, 1'b1, 32'h20);
        @(posedge clock); #1;
        drive(1'b0, 1'b0, 32'h0);
        @(negedge clock);
        chk_status("h1", 1'b0, 1'b0, 1'b0, 1'b1, 5'd8);
        @(posedge clock); #1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            chk_status($sformatf("h2_%0d", k), 1'b1, 1'b1, 1'b0, 1'b0, 5'd8);
            chk_instr($sformatf("h2_%0d", k), 32'h20, WFI);
            @(posedge clock); #1;
        end
        drive(1'b0, 1'b1, 32'h13);
        @(negedge clock);
        chk_status("h4", 1'b1, 1'b1, 1'b0, 1'b0, 5'd8);
        @(posedge clock); #1;
        drive(1'b0, 1'b0, 32'h0);
        @(negedge clock);
        chk_status("h5", 1'b0, 1'b0, 1'b0, 1'b1, 5'd4);
        @(posedge clock); #1;
        @(negedge clock);
        chk_status("h6", 1'b1, 1'b0, 1'b0, 1'b0, 5'd5);
        chk_instr("h6", 32'h10, 32'h00400013);

        // Asynchronous reset in the middle of a stall, no clock edge in between
        reset = 1'b1;
        #1;
        chk_status("arst", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk_instr("arst", 32'h0, NOP);
        @(posedge clock); #1;
        reset = 1'b0;
        drive(1'b1, 1'b0, 32'h0);
        @(negedge clock);
        chk_status("r1", 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        @(posedge clock); #1;
        @(negedge clock);
        chk_status("r2", 1'b1, 1'b0, 1'b0, 1'b1, 5'd1);
        chk_instr("r2", 32'h0, 32'h002081b3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
